// File: rtl/exu_alu_issue.sv
// Issue stage between decode and an external ALU: latches one op, holds it on the
// ALU for EXEC_CYCLES edges, then presents the captured result to writeback.
module exu_alu_issue #(
    parameter int XLEN        = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_r1,
    input  logic [XLEN-1:0] in_r2,
    input  logic [3:0]      in_sub,
    input  logic [4:0]      in_rd,
    output logic [XLEN-1:0] alu_r1,
    output logic [XLEN-1:0] alu_r2,
    output logic [3:0]      alu_sub,
    output logic            alu_enable,
    input  logic [XLEN-1:0] alu_sum,
    input  logic            alu_overflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_overflow,
    output logic [4:0]      out_rd
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          r_state, w_next;
    logic [3:0]      r_cnt;
    logic [XLEN-1:0] r_alu_r1, r_alu_r2, r_result;
    logic [3:0]      r_alu_sub;
    logic [4:0]      r_rd;
    logic            r_ovf;
    logic            w_accept;
    logic            w_finish;

    // flush blocks acceptance even though in_ready itself ignores it
    assign w_accept = in_valid && in_ready && !flush;
    assign w_finish = (r_state == EXEC) && (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (in_valid) w_next = EXEC;
                EXEC:    if (r_cnt == 4'd0) w_next = DONE;
                DONE:    if (out_ready) w_next = in_valid ? EXEC : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        out_valid  = (r_state == DONE);
        alu_enable = (r_state == EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_alu_r1  <= '0;
            r_alu_r2  <= '0;
            r_alu_sub <= '0;
            r_rd      <= '0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
        end else if (!flush) begin
            if (w_accept) begin
                r_alu_r1  <= in_r1;
                r_alu_r2  <= in_r2;
                r_alu_sub <= in_sub;
                r_rd      <= in_rd;
                r_cnt     <= 4'(EXEC_CYCLES - 1);
            end else if ((r_state == EXEC) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_finish) begin
                r_result <= alu_sum;
                r_ovf    <= alu_overflow;
            end
        end
    end

    assign alu_r1       = r_alu_r1;
    assign alu_r2       = r_alu_r2;
    assign alu_sub      = r_alu_sub;
    assign out_result   = r_result;
    assign out_overflow = r_ovf;
    assign out_rd       = r_rd;
endmodule

// File: tb/tb_exu_alu_issue.sv
// Directed bench: one instance with EXEC_CYCLES=1 and one with 3 share stimulus;
// a small ALU model (ADD / SRLI) feeds each instance's alu_sum.
module tb_exu_alu_issue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_r1, in_r2;
    logic [3:0]  in_sub;
    logic [4:0]  in_rd;

    logic        rdy_a, en_a, ov_a, val_a, rdy_b, en_b, ov_b, val_b;
    logic [31:0] ar1_a, ar2_a, res_a, ar1_b, ar2_b, res_b;
    logic [3:0]  asub_a, asub_b;
    logic [4:0]  rd_a, rd_b;
    logic [32:0] alu_a, alu_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // SRLI when sub=4'b1001, otherwise ADD with signed overflow
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
        logic [31:0] sum;
        if (s == 4'b1001) return {1'b0, a >> b[4:0]};
        sum = a + b;
        return {(a[31] == b[31]) && (sum[31] != a[31]), sum};
    endfunction

    assign alu_a = alu_f(ar1_a, ar2_a, asub_a);
    assign alu_b = alu_f(ar1_b, ar2_b, asub_b);

    exu_alu_issue #(.XLEN(32), .EXEC_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_r1(in_r1), .in_r2(in_r2), .in_sub(in_sub), .in_rd(in_rd),
        .alu_r1(ar1_a), .alu_r2(ar2_a), .alu_sub(asub_a), .alu_enable(en_a),
        .alu_sum(alu_a[31:0]), .alu_overflow(alu_a[32]),
        .out_valid(val_a), .out_ready(out_ready), .out_result(res_a),
        .out_overflow(ov_a), .out_rd(rd_a));

    exu_alu_issue #(.XLEN(32), .EXEC_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_r1(in_r1), .in_r2(in_r2), .in_sub(in_sub), .in_rd(in_rd),
        .alu_r1(ar1_b), .alu_r2(ar2_b), .alu_sub(asub_b), .alu_enable(en_b),
        .alu_sum(alu_b[31:0]), .alu_overflow(alu_b[32]),
        .out_valid(val_b), .out_ready(out_ready), .out_result(res_b),
        .out_overflow(ov_b), .out_rd(rd_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [3:0] s, input logic [4:0] rd);
        in_valid = v; in_r1 = r1; in_r2 = r2; in_sub = s; in_rd = rd;
    endtask

    logic [31:0] chain_in [4] = '{32'h8, 32'h4, 32'h2, 32'h1};
    logic [31:0] chain_ex [4] = '{32'h4, 32'h2, 32'h1, 32'h0};

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", rdy_a, 1);
        chk("rst_out_valid", val_a, 0);
        chk("rst_alu_en", en_a, 0);
        chk("rst_result", res_a, 0);
        chk("rst_rd", rd_a, 0);
        chk("rst_alu_r1", ar1_a, 0);

        // basic SRLI, single-cycle ALU
        out_ready = 1'b1;
        drive(1'b1, 32'h8, 32'h1, 4'b1001, 5'd5);
        step();
        drive(1'b0, '0, '0, '0, '0);
        chk("basic_en", en_a, 1);
        chk("basic_nv", val_a, 0);
        chk("basic_alu_r1", ar1_a, 32'h8);
        step();
        chk("basic_valid", val_a, 1);
        chk("basic_result", res_a, 32'h4);
        chk("basic_rd", rd_a, 5);
        chk("basic_ovf", ov_a, 0);
        chk("basic_en_off", en_a, 0);
        step();
        chk("basic_idle", val_a, 0);
        chk("basic_idle_rdy", rdy_a, 1);

        // back-to-back chain with no idle bubble
        drive(1'b1, chain_in[0], 32'h1, 4'b1001, 5'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("chain_exec", en_a, 1);
            drive(1'b0, '0, '0, '0, '0);
            step();
            chk("chain_valid", val_a, 1);
            chk("chain_rdy", rdy_a, 1);
            chk("chain_result", res_a, chain_ex[i]);
            if (i < 3) drive(1'b1, chain_in[i+1], 32'h1, 4'b1001, 5'd1);
            step();
        end
        chk("chain_end", val_a, 0);

        // backpressure with an overflowing ADD; a waiting op must not be taken
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        drive(1'b1, 32'h7fffffff, 32'h1, 4'b0000, 5'd9);
        step();
        drive(1'b1, 32'h10, 32'h3, 4'b0000, 5'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", val_a, 1);
            chk("bp_result", res_a, 32'h80000000);
            chk("bp_ovf", ov_a, 1);
            chk("bp_rdy", rdy_a, 0);
            chk("bp_hold_r1", ar1_a, 32'h7fffffff);
            step();
        end
        drive(1'b0, '0, '0, '0, '0);
        out_ready = 1'b1;
        step();
        chk("bp_single_xfer", val_a, 0);
        for (int i = 0; i < 4; i++) step();

        // flush in EXEC with a competing input
        drive(1'b1, 32'h20, 32'h2, 4'b1001, 5'd3);
        step();
        chk("fl_exec", en_a, 1);
        flush = 1'b1;
        drive(1'b1, 32'h40, 32'h2, 4'b1001, 5'd4);
        step();
        flush = 1'b0;
        chk("fl_valid", val_a, 0);
        chk("fl_en", en_a, 0);
        chk("fl_rdy", rdy_a, 1);
        chk("fl_not_taken", ar1_a, 32'h20);
        step();
        drive(1'b0, '0, '0, '0, '0);
        step();
        chk("fl_after_valid", val_a, 1);
        chk("fl_after_result", res_a, 32'h10);
        chk("fl_after_rd", rd_a, 4);
        for (int i = 0; i < 4; i++) step();

        // reset while holding a result in DONE
        out_ready = 1'b0;
        drive(1'b1, 32'h6, 32'h1, 4'b1001, 5'd7);
        step();
        drive(1'b0, '0, '0, '0, '0);
        step();
        chk("rs_valid_pre", val_a, 1);
        chk("rs_result_pre", res_a, 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_valid", val_a, 0);
        chk("rs_rdy", rdy_a, 1);
        chk("rs_result", res_a, 0);
        chk("rs_rd", rd_a, 0);

        // three-cycle ALU
        chk("mc_idle", rdy_b, 1);
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 32'h4, 4'b1001, 5'd2);
        step();
        drive(1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            chk("mc_en", en_b, 1);
            chk("mc_not_done", val_b, 0);
            step();
        end
        chk("mc_valid", val_b, 1);
        chk("mc_en_off", en_b, 0);
        chk("mc_result", res_b, 32'h10);
        chk("mc_rd", rd_b, 2);
        step();
        chk("mc_idle_after", val_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/exu_alu_issue.md
EXU_ALU_ISSUE -- requirements
Module: exu_alu_issue

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width.
REQ-002 SHALL have parameter EXEC_CYCLES, default 1: ALU settle cycles per op, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1: synchronous discard of the in-flight op.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake from decode.
REQ-007 SHALL have ports in_r1 and in_r2 (input, XLEN), in_sub (input, 4) and in_rd (input, 5): operands, ALU op select and destination register.
REQ-008 SHALL have ports alu_r1 and alu_r2 (output, XLEN), alu_sub (output, 4) and alu_enable (output, 1): drive to ALU.
REQ-009 SHALL have ports alu_sum (input, XLEN) and alu_overflow (input, 1): ALU result return.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake to writeback.
REQ-011 SHALL have ports out_result (output, XLEN), out_overflow (output, 1) and out_rd (output, 5): captured result, overflow flag and destination register.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-013 SHALL drive in_ready = (IDLE) or (DONE and out_ready); it is combinational from state and out_ready only.
REQ-014 SHALL accept an op on any edge with in_valid and in_ready: latch in_r1/in_r2/in_sub/in_rd into alu_r1/alu_r2/alu_sub/out_rd registers, load cnt = EXEC_CYCLES-1, enter EXEC.
REQ-015 SHALL assert alu_enable only in EXEC; alu_r1/alu_r2/alu_sub SHALL hold their last latched value in all other states.
REQ-016 SHALL, in EXEC, decrement cnt each edge while cnt != 0; on the edge with cnt == 0, capture alu_sum into out_result and alu_overflow into out_overflow, then enter DONE.
REQ-017 SHALL give latency exactly EXEC_CYCLES edges from the accepting edge to the edge at which out_valid rises.
REQ-018 SHALL assert out_valid only in DONE; out_result/out_overflow/out_rd SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, in DONE with out_ready=1 and in_valid=0, go to IDLE.
REQ-020 SHALL, in DONE with out_ready=1 and in_valid=1, retire the current op and accept the new op on the same edge, entering EXEC with no idle bubble.
REQ-021 SHALL ignore in_valid while in EXEC; the input is not consumed because in_ready=0.
REQ-022 SHALL, on flush=1, go to IDLE at the next edge from any state, discard any EXEC or DONE op, and not accept an op on that edge even if in_valid=1.
REQ-023 SHALL deassert out_valid on the edge following a flush.
REQ-024 SHALL give rst priority over flush, and flush priority over handshake activity.
REQ-025 SHALL pass alu_sum to out_result at full XLEN width with no modification.

Reset
REQ-026 SHALL, on rst=1 at an edge, enter IDLE and set cnt, alu_r1, alu_r2, alu_sub, out_result, out_rd and out_overflow to 0.
REQ-027 SHALL drive in_ready=1, out_valid=0 and alu_enable=0 in the cycle after reset.
REQ-028 SHALL, on reset mid-EXEC or mid-DONE, abandon the op with no output handshake.

Verification
REQ-029 Basic op: EXEC_CYCLES=1; send r1=32'h8, r2=32'h1, sub=4'b1001 (SRLI), rd=5 -> alu_enable=1 for 1 cycle; out_valid=1 one edge after accept with out_result=32'h4, out_rd=5, out_overflow=0.
REQ-030 Back-to-back chain: out_ready=1; send ops r1=8,4,2,1 (SRLI by 1) on consecutive accepts -> results 4,2,1,0 in order, with in_ready=1 in every DONE cycle and no IDLE cycle between ops.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_result is unchanged, in_ready=0; release -> single transfer.
REQ-032 Multi-cycle: EXEC_CYCLES=3 -> alu_enable high exactly 3 cycles; out_valid rises on the 3rd edge after accept.
REQ-033 Flush: assert flush during EXEC together with in_valid=1 -> next cycle in IDLE, out_valid=0, the input is not consumed; a subsequent op completes normally.
REQ-034 Reset: assert rst while in DONE with out_valid=1 -> next cycle out_valid=0, in_ready=1, out_result=0.
